lvds_tx: RTL and testbench



---
 rtl/lvds_tx.sv | 101 ++++++++++
 tb/tb_lvds_tx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx.sv
// Source-synchronous transmitter: FIFO-buffered words launched on clk_o falling edges, one per clk_o period.
// ready_o drops only when the FIFO is full (or in reset); en_i low idles the bus while the FIFO keeps filling.
module lvds_tx #(
    parameter int LVDS_LEN    = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int HALF_PERIOD = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [LVDS_LEN-1:0] data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [LVDS_LEN-1:0] data_o,
    output logic                strob_o,
    output logic                clk_o,
    output logic                busy_o,
    output logic [15:0]         sent_cnt_o
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HW-1:0] HLAST    = HW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic                clk_q, clk_d;
    logic [LVDS_LEN-1:0] data_q, data_d;
    logic                strob_q, strob_d;
    logic [15:0]         sent_q, sent_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [LVDS_LEN-1:0] mem_q [FIFO_DEPTH];
    logic [LVDS_LEN-1:0] mem_d [FIFO_DEPTH];
    logic                half_end, fall, full, push, pop;

    assign full       = (count_q == FULL_CNT);
    assign ready_o    = ~full & ~rst_i;
    assign busy_o     = (count_q != '0) | strob_q;
    assign data_o     = data_q;
    assign strob_o    = strob_q;
    assign clk_o      = clk_q;
    assign sent_cnt_o = sent_q;

    always_comb begin
        half_end = (hcnt_q == HLAST);
        // Launching on the clk_o fall centres data on the receiver's rising edge.
        fall     = half_end & clk_q;
        push     = valid_i & ready_o;
        pop      = fall & en_i & (count_q != '0);

        hcnt_d   = half_end ? '0 : hcnt_q + 1'b1;
        clk_d    = half_end ? ~clk_q : clk_q;

        data_d   = pop ? mem_q[rd_ptr_q] : data_q;
        strob_d  = fall ? pop : strob_q;
        sent_d   = pop ? sent_q + 16'd1 : sent_q;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q   <= '0;
            clk_q    <= 1'b0;
            data_q   <= '0;
            strob_q  <= 1'b0;
            sent_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            hcnt_q   <= hcnt_d;
            clk_q    <= clk_d;
            data_q   <= data_d;
            strob_q  <= strob_d;
            sent_q   <= sent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a zero count makes every entry dead.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: u_dut0 runs HALF_PERIOD=1, u_dut1 runs HALF_PERIOD=2, both tracked by a queue-level model.
module tb_lvds_tx;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst [2];
    logic         en [2];
    logic         vld [2];
    logic         rdy [2];
    logic         strob [2];
    logic         clko [2];
    logic         busy [2];
    logic [W-1:0] din [2];
    logic [W-1:0] dout [2];
    logic [15:0]  sent [2];

    lvds_tx #(.LVDS_LEN(W), .FIFO_DEPTH(DEPTH), .HALF_PERIOD(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .en_i(en[0]), .data_i(din[0]), .valid_i(vld[0]),
        .ready_o(rdy[0]), .data_o(dout[0]), .strob_o(strob[0]), .clk_o(clko[0]),
        .busy_o(busy[0]), .sent_cnt_o(sent[0]));

    lvds_tx #(.LVDS_LEN(W), .FIFO_DEPTH(DEPTH), .HALF_PERIOD(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .en_i(en[1]), .data_i(din[1]), .valid_i(vld[1]),
        .ready_o(rdy[1]), .data_o(dout[1]), .strob_o(strob[1]), .clk_o(clko[1]),
        .busy_o(busy[1]), .sent_cnt_o(sent[1]));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: k = edges since reset, FIFO as an array with head/tail counters.
    int           m_k [2];
    int           m_head [2];
    int           m_tail [2];
    int           m_sent [2];
    bit           m_strob [2];
    bit           m_live [2];
    logic [W-1:0] m_dat [2];
    logic [W-1:0] m_buf [2][256];

    task automatic model_step(input int i, input int hp);
        int  sz;
        bit  fall;
        bit  can_push;
        if (rst[i]) begin
            m_k[i] = 0; m_head[i] = 0; m_tail[i] = 0; m_sent[i] = 0;
            m_strob[i] = 0; m_dat[i] = '0; m_live[i] = 1;
        end else if (m_live[i]) begin
            sz       = m_tail[i] - m_head[i];
            can_push = vld[i] && (sz < DEPTH);
            fall     = (((m_k[i] + 1) % hp) == 0) && (((m_k[i] / hp) % 2) == 1);
            if (fall) begin
                if (en[i] && sz > 0) begin
                    m_dat[i]   = m_buf[i][m_head[i] % 256];
                    m_head[i]  = m_head[i] + 1;
                    m_strob[i] = 1;
                    m_sent[i]  = (m_sent[i] + 1) % 65536;
                end else begin
                    m_strob[i] = 0;
                end
            end
            if (can_push) begin
                m_buf[i][m_tail[i] % 256] = din[i];
                m_tail[i] = m_tail[i] + 1;
            end
            m_k[i] = m_k[i] + 1;
        end
    endtask

    task automatic model_check(input int i, input int hp);
        int sz;
        sz = m_tail[i] - m_head[i];
        chk($sformatf("m%0d_clk_o", i), 32'(clko[i]), 32'((m_k[i] / hp) % 2));
        chk($sformatf("m%0d_strob_o", i), 32'(strob[i]), 32'(m_strob[i]));
        chk($sformatf("m%0d_data_o", i), 32'(dout[i]), 32'(m_dat[i]));
        chk($sformatf("m%0d_sent_cnt_o", i), 32'(sent[i]), 32'(m_sent[i]));
        chk($sformatf("m%0d_ready_o", i), 32'(rdy[i]), 32'((sz < DEPTH) && !rst[i]));
        chk($sformatf("m%0d_busy_o", i), 32'(busy[i]), 32'((sz != 0) || m_strob[i]));
    endtask

    always @(posedge clk) begin
        model_step(0, 1);
        model_step(1, 2);
    end

    // Receiver on dut0: registers data on every clk_o rising edge with strobe high.
    logic [W-1:0] rx_q [$];
    bit           rx_prev = 0;

    always @(negedge clk) begin
        if (m_live[0]) model_check(0, 1);
        if (m_live[1]) model_check(1, 2);
        if (clko[0] === 1'b1 && !rx_prev && strob[0] === 1'b1) rx_q.push_back(dout[0]);
        rx_prev = (clko[0] === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int first, input int n);
        int   idx;
        int   guard;
        logic r;
        idx = 0; guard = 0;
        while (idx < n && guard < 1000) begin
            vld[0] = 1'b1;
            din[0] = 8'(first + idx);
            @(negedge clk);
            r = rdy[0];
            step();
            if (r) idx++;
            guard++;
        end
        vld[0] = 1'b0;
        chk("stream_accepted", 32'(idx), 32'(n));
    endtask

    task automatic watch_gaps(input int target, output int low);
        bit started;
        int g;
        started = 0; low = 0; g = 0;
        while (sent[0] != 16'(target) && g < 400) begin
            @(negedge clk);
            if (strob[0]) started = 1;
            else if (started) low++;
            g++;
        end
        chk("watch_sent_reached", 32'(sent[0]), 32'(16'(target)));
    endtask

    task automatic wait_sent(input int target);
        int g;
        g = 0;
        while (sent[0] != 16'(target) && g < 200) begin
            step();
            g++;
        end
        chk("wait_sent_reached", 32'(sent[0]), 32'(16'(target)));
    endtask

    task automatic check_rx(input string name, input int first, input int n);
        chk({name, "_rx_count"}, 32'(rx_q.size()), 32'(n));
        for (int j = 0; j < n && j < rx_q.size(); j++)
            chk($sformatf("%s_rx%0d", name, j), 32'(rx_q[j]), 32'(8'(first + j)));
    endtask

    typedef struct {
        logic         rst, vld, en;
        logic [W-1:0] dat;
        logic         clk, strob;
        logic [W-1:0] dout;
        logic         rdy, busy;
        logic [15:0]  sent;
    } vec_t;

    function automatic vec_t mkv(int r, int v, int e, int d, int c, int s, int o, int y, int b, int n);
        vec_t x;
        x.rst = (r != 0); x.vld = (v != 0); x.en = (e != 0); x.dat = 8'(d);
        x.clk = (c != 0); x.strob = (s != 0); x.dout = 8'(o);
        x.rdy = (y != 0); x.busy = (b != 0); x.sent = 16'(n);
        return x;
    endfunction

    initial begin
        vec_t vec [15];
        int   base;
        int   low;
        int   g;
        int   hi;

        //           rst vld en  dat   clk strob dout  rdy busy sent
        vec[0]  = mkv(1, 1, 1, 'h11,  0, 0, 'h00, 0, 0, 0);
        vec[1]  = mkv(1, 1, 1, 'h11,  0, 0, 'h00, 0, 0, 0);
        vec[2]  = mkv(1, 1, 1, 'h11,  0, 0, 'h00, 0, 0, 0);
        vec[3]  = mkv(0, 1, 0, 'h11,  1, 0, 'h00, 1, 1, 0);
        vec[4]  = mkv(0, 0, 1, 'h00,  0, 1, 'h11, 1, 1, 1);
        vec[5]  = mkv(0, 1, 1, 'h22,  1, 1, 'h11, 1, 1, 1);
        vec[6]  = mkv(0, 0, 0, 'h00,  0, 0, 'h11, 1, 1, 1);
        vec[7]  = mkv(0, 0, 1, 'h00,  1, 0, 'h11, 1, 1, 1);
        vec[8]  = mkv(0, 0, 1, 'h00,  0, 1, 'h22, 1, 1, 2);
        vec[9]  = mkv(0, 0, 1, 'h00,  1, 1, 'h22, 1, 1, 2);
        vec[10] = mkv(0, 0, 1, 'h00,  0, 0, 'h22, 1, 0, 2);
        vec[11] = mkv(0, 0, 1, 'h00,  1, 0, 'h22, 1, 0, 2);
        vec[12] = mkv(0, 1, 1, 'h33,  0, 0, 'h22, 1, 1, 2);
        vec[13] = mkv(0, 0, 1, 'h00,  1, 0, 'h22, 1, 1, 2);
        vec[14] = mkv(0, 0, 1, 'h00,  0, 1, 'h33, 1, 1, 3);

        rst[1] = 1'b1; en[1] = 1'b0; vld[1] = 1'b0; din[1] = '0;
        for (int r = 0; r < 15; r++) begin
            rst[0] = vec[r].rst; vld[0] = vec[r].vld; en[0] = vec[r].en; din[0] = vec[r].dat;
            step();
            chk($sformatf("vec%0d_clk_o", r), 32'(clko[0]), 32'(vec[r].clk));
            chk($sformatf("vec%0d_strob_o", r), 32'(strob[0]), 32'(vec[r].strob));
            chk($sformatf("vec%0d_data_o", r), 32'(dout[0]), 32'(vec[r].dout));
            chk($sformatf("vec%0d_ready_o", r), 32'(rdy[0]), 32'(vec[r].rdy));
            chk($sformatf("vec%0d_busy_o", r), 32'(busy[0]), 32'(vec[r].busy));
            chk($sformatf("vec%0d_sent_cnt_o", r), 32'(sent[0]), 32'(vec[r].sent));
        end
        vld[0] = 1'b0;
        rst[1] = 1'b0; en[1] = 1'b1;

        // Streaming: continuous strobe, every value received once in order.
        repeat (4) step();
        rx_q.delete();
        base = int'(sent[0]);
        fork
            stream(0, 20);
            watch_gaps(base + 20, low);
        join
        repeat (4) step();
        chk("stream_strobe_gaps", 32'(low), 32'd0);
        check_rx("stream", 0, 20);

        // Enable gap of three clk_o periods mid-stream.
        repeat (4) step();
        rx_q.delete();
        base = int'(sent[0]);
        fork
            stream('h10, 8);
            watch_gaps(base + 8, low);
            begin
                g = 0;
                while (sent[0] != 16'(base + 3) && g < 200) begin step(); g++; end
                en[0] = 1'b0;
                repeat (6) step();
                en[0] = 1'b1;
            end
        join
        repeat (4) step();
        chk("gap_strobe_low_cycles", 32'(low), 32'd6);
        check_rx("gap", 'h10, 8);

        // Backpressure: FIFO fills with en low, fifth word waits for space.
        repeat (4) step();
        rx_q.delete();
        base = int'(sent[0]);
        en[0] = 1'b0;
        stream('h40, 4);
        chk("bp_ready_when_full", 32'(rdy[0]), 32'd0);
        vld[0] = 1'b1; din[0] = 8'h44;
        repeat (3) step();
        chk("bp_ready_held_low", 32'(rdy[0]), 32'd0);
        en[0] = 1'b1;
        stream('h44, 1);
        wait_sent(base + 5);
        repeat (4) step();
        check_rx("bp", 'h40, 5);

        // Reset with three words queued and one on the bus.
        repeat (4) step();
        en[0] = 1'b0;
        stream('h50, 4);
        en[0] = 1'b1;
        g = 0;
        while (!strob[0] && g < 20) begin step(); g++; end
        chk("rstmid_pre_strob", 32'(strob[0]), 32'd1);
        rst[0] = 1'b1;
        step();
        chk("rstmid_clk_o", 32'(clko[0]), 32'd0);
        chk("rstmid_strob_o", 32'(strob[0]), 32'd0);
        chk("rstmid_data_o", 32'(dout[0]), 32'd0);
        chk("rstmid_busy_o", 32'(busy[0]), 32'd0);
        chk("rstmid_ready_o", 32'(rdy[0]), 32'd0);
        chk("rstmid_sent_cnt_o", 32'(sent[0]), 32'd0);
        rst[0] = 1'b0;
        rx_q.delete();
        repeat (20) step();
        chk("rstmid_after_sent", 32'(sent[0]), 32'd0);
        chk("rstmid_after_rx", 32'(rx_q.size()), 32'd0);
        chk("rstmid_after_busy", 32'(busy[0]), 32'd0);

        // Single word at HALF_PERIOD=2.
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0; en[1] = 1'b1; vld[1] = 1'b1; din[1] = 8'hA5;
        step();
        vld[1] = 1'b0;
        g = 0;
        while (!strob[1] && g < 20) begin step(); g++; end
        chk("single_latency_in_range", 32'(g >= 1 && g <= 5), 32'd1);
        hi = 0;
        while (strob[1] && hi < 20) begin hi++; step(); end
        chk("single_strobe_cycles", 32'(hi), 32'd4);
        chk("single_data_held", 32'(dout[1]), 32'hA5);
        chk("single_sent_cnt", 32'(sent[1]), 32'd1);

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                rst[i] = ($urandom_range(0, 149) == 0);
                vld[i] = ($urandom_range(0, 2) != 0);
                en[i]  = ($urandom_range(0, 3) != 0);
                din[i] = 8'($urandom);
            end
            step();
        end
        rst[0] = 1'b0; rst[1] = 1'b0; vld[0] = 1'b0; vld[1] = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
